// File: rtl/vga_bus_arbiter.sv
// Two-requester round-robin arbiter and strobe sequencer for the VGA card's ISA-style bus.
// Each granted cycle runs ADDR -> CMD (with WAIT extension and timeout) -> HOLD; all outputs are registered.
module vga_bus_arbiter #(
  parameter int SETUP_CYC   = 2,
  parameter int CMD_CYC     = 4,
  parameter int HOLD_CYC    = 2,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic        mclk,
  input  logic        reset,
  input  logic [1:0]  req,
  input  logic [1:0]  req_io,
  input  logic [1:0]  req_rw,
  input  logic [3:0]  req_addr,
  input  logic [31:0] req_wdata,
  output logic [1:0]  gnt,
  output logic [1:0]  ack,
  output logic [15:0] rdata,
  output logic        timeout,
  output logic        busy,
  output logic        BALE,
  output logic        MEMR,
  output logic        MEMW,
  output logic        IOR,
  output logic        IOW,
  output logic        SA0,
  output logic        SA12,
  output logic [15:0] DG_out,
  output logic        DG_oe,
  input  logic [15:0] DG_in,
  input  logic        WAIT
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR,
    S_CMD,
    S_HOLD
  } state_e;

  localparam logic [3:0] SETUP_LAST  = 4'(SETUP_CYC - 1);
  localparam logic [3:0] CMD_LAST    = 4'(CMD_CYC - 1);
  localparam logic [3:0] HOLD_LAST   = 4'(HOLD_CYC - 1);
  localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT_CYC);

  state_e      state_q, state_d;
  logic [3:0]  phase_q, phase_d;
  logic [7:0]  wait_q, wait_d;
  logic        last_q, last_d;
  logic        own_q, own_d;
  logic        io_q, io_d;
  logic        rw_q, rw_d;
  logic [1:0]  gnt_q, gnt_d;
  logic [1:0]  ack_q, ack_d;
  logic [15:0] rdata_q, rdata_d;
  logic        timeout_q, timeout_d;
  logic        busy_q, busy_d;
  logic        bale_q, bale_d;
  logic        memr_q, memr_d;
  logic        memw_q, memw_d;
  logic        ior_q, ior_d;
  logic        iow_q, iow_d;
  logic        sa0_q, sa0_d;
  logic        sa12_q, sa12_d;
  logic [15:0] dg_out_q, dg_out_d;
  logic        dg_oe_q, dg_oe_d;

  logic        pick;
  logic        cmd_done;
  logic        cmd_tmo;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can leave one unassigned and infer a latch.
    state_d   = state_q;
    phase_d   = phase_q;
    wait_d    = wait_q;
    last_d    = last_q;
    own_d     = own_q;
    io_d      = io_q;
    rw_d      = rw_q;
    gnt_d     = gnt_q;
    ack_d     = 2'b00;
    rdata_d   = rdata_q;
    timeout_d = 1'b0;
    bale_d    = bale_q;
    memr_d    = memr_q;
    memw_d    = memw_q;
    ior_d     = ior_q;
    iow_d     = iow_q;
    sa0_d     = sa0_q;
    sa12_d    = sa12_q;
    dg_out_d  = dg_out_q;
    dg_oe_d   = dg_oe_q;
    pick      = 1'b0;
    cmd_done  = 1'b0;
    cmd_tmo   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (req != 2'b00) begin
          // With both pending, the requester that did not win last time goes next.
          pick     = (req == 2'b11) ? ~last_q : req[1];
          own_d    = pick;
          last_d   = pick;
          io_d     = req_io[pick];
          rw_d     = req_rw[pick];
          gnt_d    = pick ? 2'b10 : 2'b01;
          sa0_d    = pick ? req_addr[2] : req_addr[0];
          sa12_d   = pick ? req_addr[3] : req_addr[1];
          bale_d   = 1'b0;
          if (!req_rw[pick]) begin
            dg_oe_d  = 1'b1;
            dg_out_d = pick ? req_wdata[31:16] : req_wdata[15:0];
          end
          wait_d   = 8'd0;
          phase_d  = 4'd0;
          state_d  = S_ADDR;
        end
      end

      S_ADDR: begin
        if (phase_q == SETUP_LAST) begin
          bale_d  = 1'b1;
          unique case ({io_q, rw_q})
            2'b00: memw_d = 1'b0;
            2'b01: memr_d = 1'b0;
            2'b10: iow_d  = 1'b0;
            2'b11: ior_d  = 1'b0;
          endcase
          phase_d = 4'd0;
          state_d = S_CMD;
        end else begin
          phase_d = phase_q + 4'd1;
        end
      end

      S_CMD: begin
        // WAIT matters only from the last minimum cycle on, and only for memory cycles.
        if (phase_q != CMD_LAST) begin
          phase_d = phase_q + 4'd1;
        end else if (io_q || WAIT) begin
          cmd_done = 1'b1;
        end else if (wait_q == TIMEOUT_LIM) begin
          cmd_done = 1'b1;
          cmd_tmo  = 1'b1;
        end else begin
          wait_d = wait_q + 8'd1;
        end

        if (cmd_done) begin
          memr_d    = 1'b1;
          memw_d    = 1'b1;
          ior_d     = 1'b1;
          iow_d     = 1'b1;
          ack_d     = own_q ? 2'b10 : 2'b01;
          timeout_d = cmd_tmo;
          if (rw_q) begin
            rdata_d = cmd_tmo ? 16'hFFFF : DG_in;
          end
          phase_d   = 4'd0;
          state_d   = S_HOLD;
        end
      end

      S_HOLD: begin
        if (phase_q == HOLD_LAST) begin
          sa0_d    = 1'b1;
          sa12_d   = 1'b1;
          dg_oe_d  = 1'b0;
          dg_out_d = 16'hFFFF;
          gnt_d    = 2'b00;
          phase_d  = 4'd0;
          state_d  = S_IDLE;
        end else begin
          phase_d = phase_q + 4'd1;
        end
      end

      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge mclk) begin
    // NOTE: state is updated with non-blocking assignments so every flop samples the pre-edge values.
    if (reset) begin
      state_q   <= S_IDLE;
      phase_q   <= 4'd0;
      wait_q    <= 8'd0;
      last_q    <= 1'b1;
      own_q     <= 1'b0;
      io_q      <= 1'b0;
      rw_q      <= 1'b0;
      gnt_q     <= 2'b00;
      ack_q     <= 2'b00;
      rdata_q   <= 16'hFFFF;
      timeout_q <= 1'b0;
      busy_q    <= 1'b0;
      bale_q    <= 1'b1;
      memr_q    <= 1'b1;
      memw_q    <= 1'b1;
      ior_q     <= 1'b1;
      iow_q     <= 1'b1;
      sa0_q     <= 1'b1;
      sa12_q    <= 1'b1;
      dg_out_q  <= 16'hFFFF;
      dg_oe_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      wait_q    <= wait_d;
      last_q    <= last_d;
      own_q     <= own_d;
      io_q      <= io_d;
      rw_q      <= rw_d;
      gnt_q     <= gnt_d;
      ack_q     <= ack_d;
      rdata_q   <= rdata_d;
      timeout_q <= timeout_d;
      busy_q    <= busy_d;
      bale_q    <= bale_d;
      memr_q    <= memr_d;
      memw_q    <= memw_d;
      ior_q     <= ior_d;
      iow_q     <= iow_d;
      sa0_q     <= sa0_d;
      sa12_q    <= sa12_d;
      dg_out_q  <= dg_out_d;
      dg_oe_q   <= dg_oe_d;
    end
  end

  assign gnt     = gnt_q;
  assign ack     = ack_q;
  assign rdata   = rdata_q;
  assign timeout = timeout_q;
  assign busy    = busy_q;
  assign BALE    = bale_q;
  assign MEMR    = memr_q;
  assign MEMW    = memw_q;
  assign IOR     = ior_q;
  assign IOW     = iow_q;
  assign SA0     = sa0_q;
  assign SA12    = sa12_q;
  assign DG_out  = dg_out_q;
  assign DG_oe   = dg_oe_q;

endmodule
